// File: rtl/draw_map_scroll.sv
// Scrolling tile-map renderer: screen x/y -> scaled, scrolled ROM address, 2-cycle pipeline.
// Optional macro DRAW_MAP_WRAP_EN: scrolled coordinates past the map edge wrap (toroidal map).
module draw_map_scroll #(
  parameter int          MAP_W       = 240,
  parameter int          MAP_H       = 240,
  parameter int          NUM_MAPS    = 2,
  parameter int          SCALE_SHIFT = 1,
  parameter int          ADDR_W      = 17,
  parameter logic [11:0] NULL_COLOR  = 12'h000,
  localparam int         SEL_W       = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [10:0]       x,
  input  logic [10:0]       y,
  input  logic              scroll_we,
  input  logic [9:0]        scroll_x,
  input  logic [9:0]        scroll_y,
  input  logic [SEL_W-1:0]  map_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [11:0]       color,
  output logic              color_valid
);

  localparam int CW = 12;
  localparam logic [CW-1:0]     W_C    = CW'(MAP_W);
  localparam logic [CW-1:0]     H_C    = CW'(MAP_H);
  localparam logic [SEL_W:0]    NM_C   = (SEL_W+1)'(NUM_MAPS);
  localparam logic [ADDR_W-1:0] MAP_SZ = ADDR_W'(MAP_W * MAP_H);
  localparam logic [ADDR_W-1:0] ROW_SZ = ADDR_W'(MAP_W);

  logic [9:0]       pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [SEL_W-1:0] pend_map_q, pend_map_d;
  logic [9:0]       off_x_q, off_y_q;
  logic [SEL_W-1:0] map_idx_q;

  logic [CW-1:0]    sx, sy, cx_raw, cy_raw, cx_d, cy_d;
  logic             in_d, wr_ok;

  logic [CW-1:0]    cx_q, cy_q;
  logic [SEL_W-1:0] map_q;
  logic             in_q, vld_q;
  logic [11:0]      color_q;
  logic             color_valid_q;

  // Pending registers; a write with any out-of-range field is dropped as a whole.
  always_comb begin
    wr_ok = scroll_we
          && ({2'b00, scroll_x} < W_C)
          && ({2'b00, scroll_y} < H_C)
          && ({1'b0, map_sel} < NM_C);
    pend_x_d   = pend_x_q;
    pend_y_d   = pend_y_q;
    pend_map_d = pend_map_q;
    if (wr_ok) begin
      pend_x_d   = scroll_x;
      pend_y_d   = scroll_y;
      pend_map_d = map_sel;
    end
  end

  always_comb begin
    sx     = CW'(x >> SCALE_SHIFT);
    sy     = CW'(y >> SCALE_SHIFT);
    cx_raw = sx + {2'b00, off_x_q};
    cy_raw = sy + {2'b00, off_y_q};
    in_d   = (sx < W_C) && (sy < H_C);
`ifdef DRAW_MAP_WRAP_EN
    cx_d   = (cx_raw >= W_C) ? cx_raw - W_C : cx_raw;
    cy_d   = (cy_raw >= H_C) ? cy_raw - H_C : cy_raw;
`else
    cx_d   = cx_raw;
    cy_d   = cy_raw;
    if ((cx_raw >= W_C) || (cy_raw >= H_C)) in_d = 1'b0;
`endif
  end

  // Active registers load from the pending next-state so a same-cycle write is applied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_x_q   <= '0;
      pend_y_q   <= '0;
      pend_map_q <= '0;
      off_x_q    <= '0;
      off_y_q    <= '0;
      map_idx_q  <= '0;
    end else begin
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
      pend_map_q <= pend_map_d;
      if (frame_start) begin
        off_x_q   <= pend_x_d;
        off_y_q   <= pend_y_d;
        map_idx_q <= pend_map_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      in_q  <= 1'b0;
      cx_q  <= '0;
      cy_q  <= '0;
      map_q <= '0;
    end else begin
      vld_q <= pix_valid;
      if (pix_valid) begin
        in_q  <= in_d;
        cx_q  <= cx_d;
        cy_q  <= cy_d;
        map_q <= map_idx_q;
      end
    end
  end

  assign rom_addr = ADDR_W'(map_q) * MAP_SZ + ADDR_W'(cy_q) * ROW_SZ + ADDR_W'(cx_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_q       <= NULL_COLOR;
      color_valid_q <= 1'b0;
    end else begin
      color_valid_q <= vld_q;
      if (vld_q) color_q <= in_q ? rom_data : NULL_COLOR;
    end
  end

  assign color       = color_q;
  assign color_valid = color_valid_q;

endmodule

// File: tb/tb_draw_map_scroll.sv
// Scoreboard bench for draw_map_scroll: behavioural model pushes expectations, monitor pops on color_valid.
module tb_draw_map_scroll;

  localparam int          MW = 240;
  localparam int          MH = 240;
  localparam int          NM = 2;
  localparam int          AW = 17;
  localparam logic [11:0] NC = 12'hF0F;

  typedef struct {
    bit          inmap;
    int          addr;
    logic [11:0] col;
  } exp_t;

  logic          clk, rst, frame_start, pix_valid, scroll_we;
  logic [10:0]   x, y;
  logic [9:0]    scroll_x, scroll_y;
  logic [0:0]    map_sel;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data, color;
  logic          color_valid;

  draw_map_scroll #(
    .MAP_W(MW), .MAP_H(MH), .NUM_MAPS(NM), .SCALE_SHIFT(1), .ADDR_W(AW), .NULL_COLOR(NC)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .x(x), .y(y), .scroll_we(scroll_we), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .map_sel(map_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .color(color), .color_valid(color_valid)
  );

  function automatic logic [11:0] rom_f(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a * 17'd7 + (a >> 5);
    return t[11:0] ^ 12'h5A5;
  endfunction

  assign rom_data = rom_f(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  // Reference state: pending and active scroll registers.
  int m_px = 0, m_py = 0, m_pm = 0, m_ox = 0, m_oy = 0, m_map = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model_pixel(input int px, input int py);
    exp_t e;
    int sx, sy, cx, cy;
    sx = px / 2;
    sy = py / 2;
    e.inmap = (sx < MW) && (sy < MH);
    cx = sx + m_ox;
    cy = sy + m_oy;
`ifdef DRAW_MAP_WRAP_EN
    if (cx >= MW) cx -= MW;
    if (cy >= MH) cy -= MH;
`else
    if (cx >= MW || cy >= MH) e.inmap = 0;
`endif
    e.addr = m_map * MW * MH + cy * MW + cx;
    e.col  = e.inmap ? rom_f(AW'(e.addr)) : NC;
    return e;
  endfunction

  // Drive one cycle's inputs (called #1 after a rising edge), update model, advance to next edge.
  task automatic step(input bit pv, input int px, input int py,
                      input bit we, input int scx, input int scy, input int ms, input bit fs);
    pix_valid   = pv;
    x           = 11'(px);
    y           = 11'(py);
    scroll_we   = we;
    scroll_x    = 10'(scx);
    scroll_y    = 10'(scy);
    map_sel     = 1'(ms);
    frame_start = fs;
    if (pv) q.push_back(model_pixel(px, py));
    if (we && scx < MW && scy < MH && ms < NM) begin
      m_px = scx; m_py = scy; m_pm = ms;
    end
    if (fs) begin
      m_ox = m_px; m_oy = m_py; m_map = m_pm;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [AW-1:0] prev_addr = '0;

  // Monitor: rom_addr seen one negedge before color_valid belongs to that pixel.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (color_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got color %0h with no pixel outstanding", color);
        end else begin
          e = q.pop_front();
          chk("color", int'(color), int'(e.col));
          if (e.inmap) chk("rom_addr", int'(prev_addr), e.addr);
        end
      end
      prev_addr = rom_addr;
    end
  end

  initial begin
    rst = 1'b1;
    pix_valid = 0; frame_start = 0; scroll_we = 0;
    x = '0; y = '0; scroll_x = '0; scroll_y = '0; map_sel = '0;
    #12;
    chk("reset_color", int'(color), int'(NC));
    chk("reset_valid", int'(color_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic address and latency
    step(1, 10, 4, 0, 0, 0, 0, 0);
    chk("basic_addr", int'(rom_addr), 485);
    chk("basic_valid_lat1", int'(color_valid), 0);
    idle(1);
    chk("basic_valid_lat2", int'(color_valid), 1);

    // Out-of-map
    step(1, 1100, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Scroll wrap
    step(0, 0, 0, 1, 200, 0, 0, 1);
    step(1, 100, 0, 0, 0, 0, 0, 0);
`ifdef DRAW_MAP_WRAP_EN
    chk("wrap_addr", int'(rom_addr), 10);
`endif
    idle(2);

    // Double-buffered map select, then illegal write
    step(0, 0, 0, 1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 0, 1, 0);
    chk("pending_not_applied", int'(rom_addr), 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("map1_addr", int'(rom_addr), 57600);
    step(0, 0, 0, 1, 300, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("illegal_ignored", int'(rom_addr), 57600);

    // Same-cycle write and frame_start
    step(0, 0, 0, 1, 0, 5, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("same_cycle_addr", int'(rom_addr), 1200);
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 1300)), int'($urandom_range(0, 600)),
           $urandom_range(0, 9) < 2, int'($urandom_range(0, 320)), int'($urandom_range(0, 320)),
           int'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
    end

    // Reset with pixels in flight
    step(0, 0, 0, 1, 37, 12, 1, 1);
    step(1, 20, 30, 0, 0, 0, 0, 0);
    step(1, 22, 30, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid_now", int'(color_valid), 0);
    chk("rst_color_now", int'(color), int'(NC));
    q.delete();
    m_px = 0; m_py = 0; m_pm = 0; m_ox = 0; m_oy = 0; m_map = 0;
    pix_valid = 0; frame_start = 0; scroll_we = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_addr", int'(rom_addr), 0);
    idle(4);

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
